// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants for the sequential FIR engine:
//   W / WA / FRAC : sample width (Q10.14), accumulator width (Q20.28),
//                   fractional bits of the sample format
//   NTAPS         : size of the coefficient table (upper bound on taps)
//   COEF          : signed Q10.14 coefficients, index 0 multiplies the newest
//                   sample
//   IDLE/MAC/DONE : sequencer state encoding
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int W     = 25;
    localparam int WA    = 49;
    localparam int FRAC  = 14;
    localparam int NTAPS = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t MAC  = 2'd1;
    localparam state_t DONE = 2'd2;

    // 1.0, 0.5, 0.25, 0.0, then a short decaying tail for 8-tap builds.
    localparam logic signed [W-1:0] COEF [NTAPS] = '{
        25'sh0004000,
        25'sh0002000,
        25'sh0001000,
        25'sh0000000,
        25'sh0000800,
        25'sh0000400,
        25'sh0000200,
        25'sh0000100
    };

endpackage

// File: rtl/operac.sv
// ---------------------------------------------------------------------------
// operac
// Combinational multiply-accumulate: out = in_acum + in * cte, modulo 2^WA.
//   in      : sample, Q10.14 signed
//   cte     : coefficient, Q10.14 signed
//   in_acum : running sum, Q20.28 signed
//   out     : updated sum, Q20.28 signed
// The full product is Q20.28 in 2*W bits; only the low WA bits take part so
// the sum wraps exactly like a WA-bit register would.
// ---------------------------------------------------------------------------
module operac
    import fir_pkg::*;
(
    input  logic signed [W-1:0]  in,
    input  logic signed [W-1:0]  cte,
    input  logic signed [WA-1:0] in_acum,
    output logic signed [WA-1:0] out
);

    logic signed [2*W-1:0] w_prod;

    assign w_prod = in * cte;
    assign out    = in_acum + $signed(w_prod[WA-1:0]);

endmodule

// File: rtl/fir_mac_seq.sv
// ---------------------------------------------------------------------------
// fir_mac_seq
// Sequential FIR engine: keeps the last NTAPS samples and walks one tap per
// clock through operac, then rounds (half up) and saturates the Q20.28 sum
// back to a Q10.14 sample.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high, clears all state
//   in_valid  : one-cycle strobe, in_data holds a new sample
//   in_data   : new sample, Q10.14
//   busy      : high while a sample is being processed (accept only when low)
//   out_valid : one-cycle pulse, out_data/sat updated
//   out_data  : filtered sample, Q10.14, held until the next out_valid
//   sat       : out_data was clipped
//   overrun   : sticky, in_valid arrived while busy
// Latency: accept on edge T, taps on T+1..T+NTAPS, result registered on
// T+NTAPS+1, so a new sample may be accepted in the out_valid cycle.
// ---------------------------------------------------------------------------
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int W     = fir_pkg::W,
    parameter int WA    = fir_pkg::WA,
    parameter int FRAC  = fir_pkg::FRAC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    output logic                busy,
    output logic                out_valid,
    output logic signed [W-1:0] out_data,
    output logic                sat,
    output logic                overrun
);

    localparam int KW = $clog2(NTAPS);
    localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);
    localparam logic signed [WA-1:0] RND_HALF = {{(WA-1){1'b0}}, 1'b1} << (FRAC - 1);

    // Add half an output LSB; plain wrap, the range check follows.
    function automatic logic signed [WA-1:0] round_half_up(input logic signed [WA-1:0] acc);
        return acc + RND_HALF;
    endfunction

    // Returns {sat, sample}. The sample fits when every bit above the output
    // MSB is a copy of the sign bit; otherwise clip toward the sign.
    function automatic logic [W:0] saturate(input logic signed [WA-1:0] r);
        logic [WA-W-FRAC:0] top_bits;
        top_bits = r[WA-1:W+FRAC-1];
        if ((&top_bits) || !(|top_bits))
            return {1'b0, r[W+FRAC-1:FRAC]};
        else if (!r[WA-1])
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        else
            return {1'b1, 1'b1, {(W-1){1'b0}}};
    endfunction

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic signed [WA-1:0]  r_acc;
    logic signed [W-1:0]   r_x [NTAPS];
    logic                  r_out_valid;
    logic signed [W-1:0]   r_out_data;
    logic                  r_sat;
    logic                  r_overrun;

    logic signed [W-1:0]   w_coef [NTAPS];
    logic signed [WA-1:0]  w_acc_next;
    logic [W:0]            w_rs;

    // Local copy of the first NTAPS package coefficients, sized so r_k
    // indexes it exactly.
    for (genvar i = 0; i < NTAPS; i++) begin : g_coef
        assign w_coef[i] = COEF[i];
    end

    // Tap stage: one multiply-accumulate per clock.
    operac u_operac (
        .in      (r_x[r_k]),
        .cte     (w_coef[r_k]),
        .in_acum (r_acc),
        .out     (w_acc_next)
    );

    // Output stage: round and range-check the finished sum.
    assign w_rs = saturate(round_half_up(r_acc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    if (r_k == K_LAST) r_state <= DONE;
                end
                DONE: begin
                    r_out_data  <= w_rs[W-1:0];
                    r_sat       <= w_rs[W];
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Samples offered while busy are dropped; remember it until reset.
            if (in_valid && (r_state != IDLE)) r_overrun <= 1'b1;
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat       = r_sat;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_seq
// Scoreboard bench for fir_mac_seq with NTAPS=4, coefficients 1.0/0.5/0.25/0.
// The driver models acceptance timing and the filtered result with plain
// integer arithmetic and queues the expected output; a negedge monitor pops
// and compares on every out_valid, and tracks busy/overrun each cycle.
// ---------------------------------------------------------------------------
module tb_fir_mac_seq;

    localparam int NT = 4;
    localparam int W  = 25;
    localparam longint SMAX = 64'sd16777215;
    localparam longint SMIN = -64'sd16777216;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                busy;
    logic                out_valid;
    logic signed [W-1:0] out_data;
    logic                sat;
    logic                overrun;

    fir_mac_seq #(.NTAPS(NT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        longint sat;
        int     due;
    } exp_t;

    longint coef [NT] = '{64'sd16384, 64'sd8192, 64'sd4096, 64'sd0};
    longint hist [NT];
    exp_t   sb [$];
    exp_t   mon_e;
    int     cyc = 0;
    int     m_last_t = -1000;
    int     m_ovr_edge = -1;
    int     n_tests = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: dot product of history and coefficients, round half up,
    // floor to the sample grid, clip to the signed 25-bit range.
    function automatic exp_t model_out(input int t);
        exp_t   e;
        longint s;
        longint q;
        s = 0;
        for (int i = 0; i < NT; i++) s += hist[i] * coef[i];
        q = (s + 64'sd8192) >>> 14;
        if (q > SMAX) begin
            e.data = SMAX; e.sat = 1;
        end else if (q < SMIN) begin
            e.data = SMIN; e.sat = 1;
        end else begin
            e.data = q; e.sat = 0;
        end
        e.due = t + NT + 1;
        return e;
    endfunction

    // Present (v, d) for one clock; the consuming edge is cyc+1.
    task automatic drive(input logic v, input longint d);
        int t;
        in_valid = v;
        in_data  = d[W-1:0];
        if (v) begin
            t = cyc + 1;
            if (t >= m_last_t + NT + 2) begin
                for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = longint'(in_data);
                sb.push_back(model_out(t));
                m_last_t = t;
            end else if (m_ovr_edge < 0) begin
                m_ovr_edge = t;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One sample at the full sustained rate (next accept in the out_valid cycle).
    task automatic send(input longint d);
        drive(1'b1, d);
        repeat (NT + 1) drive(1'b0, 0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        sb.delete();
        m_last_t   = -1000;
        m_ovr_edge = -1;
        for (int i = 0; i < NT; i++) hist[i] = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, longint'(cyc >= m_last_t && cyc <= m_last_t + NT));
            chk("overrun", overrun, longint'(m_ovr_edge >= 0 && cyc >= m_ovr_edge));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_sat", sat, mon_e.sat);
                    chk("out_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        longint r;
        for (int i = 0; i < NT; i++) hist[i] = 0;
        #2;
        do_reset();

        // Impulse response.
        send(16384);
        repeat (3) send(0);

        // Rounding: exact LSB, half LSB up, quarter LSB down, negative side.
        send(1);
        send(0);
        send(0);
        send(-1);
        send(0);
        send(0);
        send(0);

        // Saturation both ways.
        repeat (3) send(SMAX);
        repeat (3) send(SMIN);
        repeat (NT) send(0);

        // Back-to-back random samples.
        for (int n = 0; n < 10; n++) begin
            r = longint'($signed(25'($urandom)));
            send(r);
        end
        repeat (NT + 2) drive(1'b0, 0);

        // Overrun: second pulse two cycles later must be dropped.
        drive(1'b1, 123456);
        drive(1'b0, 0);
        drive(1'b1, 777777);
        repeat (NT + 3) drive(1'b0, 0);
        repeat (NT) send(0);
        chk("overrun_sticky", overrun, 1);

        // Reset mid-MAC, then impulse from clean history.
        do_reset();
        send(5000);
        drive(1'b1, 9000);
        drive(1'b0, 0);
        drive(1'b0, 0);
        do_reset();
        repeat (NT + 4) drive(1'b0, 0);
        send(16384);
        repeat (3) send(0);

        // Random bursts, gaps and multi-cycle strobes.
        for (int n = 0; n < 200; n++) begin
            int len;
            int gap;
            len = $urandom_range(1, 3);
            gap = $urandom_range(0, 8);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0)
                    r = ($urandom_range(0, 1) == 1) ? SMAX : SMIN;
                else
                    r = longint'($signed(25'($urandom)));
                drive(1'b1, r);
            end
            repeat (gap) drive(1'b0, 0);
        end

        repeat (NT + 4) drive(1'b0, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
